// File: rtl/spi_cfg_regbank.sv
// spi_cfg_regbank: SPI-slave configuration register bank with framed writes, per-register strobes and frame errors.
// Defining SPI_READBACK_EN adds the miso port and serial readback of the addressed register.
module spi_cfg_regbank #(
  parameter int unsigned       ADDR_W      = 4,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_REGS    = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck,
  input  logic                       mosi,
  input  logic                       csb,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
`ifdef SPI_READBACK_EN
  ,
  output logic                       miso
`endif
);

  localparam int unsigned       FRAME_LEN  = 1 + ADDR_W + DATA_W;
  localparam int unsigned       CNT_W      = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_OVR    = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_csb_sync;
  logic                   r_sck_d, r_csb_d;
  logic                   w_sck_s, w_mosi_s, w_csb_s, w_sck_rise, w_csb_fall;
  logic                   w_clear, w_shift, w_commit;
  logic [CNT_W-1:0]       r_cnt;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic                   w_rw, w_in_range, w_full, w_wr_ok, w_rd_ok, w_err;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W-1:0]      w_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_csb_sync  <= '1;
      r_sck_d     <= 1'b0;
      r_csb_d     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
      r_sck_d     <= w_sck_s;
      r_csb_d     <= w_csb_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_csb_s    = r_csb_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_csb_fall = ~w_csb_s & r_csb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A clock edge coinciding with CSb release is dropped: the csb test wins in SHIFT.
  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: if (w_csb_fall) begin
        w_next  = SHIFT;
        w_clear = 1'b1;
      end
      SHIFT: begin
        if (w_csb_s)         w_next  = COMMIT;
        else if (w_sck_rise) w_shift = 1'b1;
      end
      COMMIT: begin
        w_commit = 1'b1;
        if (!w_csb_s) begin
          w_next  = SHIFT;
          w_clear = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_shift) begin
      if (r_cnt < CNT_FULL) r_shift <= {r_shift[FRAME_LEN-2:0], w_mosi_s};
      if (r_cnt != CNT_OVR) r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_rw       = r_shift[FRAME_LEN-1];
  assign w_addr     = r_shift[DATA_W +: ADDR_W];
  assign w_data     = r_shift[DATA_W-1:0];
  assign w_in_range = {1'b0, w_addr} < NUM_REGS_W;
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_wr_ok    = w_commit & w_full & ~w_rw & w_in_range;
`ifdef SPI_READBACK_EN
  assign w_rd_ok    = w_commit & w_full & w_rw & w_in_range;
`else
  assign w_rd_ok    = 1'b0;
`endif
  assign w_err      = w_commit & (r_cnt != '0) & ~w_wr_ok & ~w_rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= w_err;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (w_wr_ok && (w_addr == ADDR_W'(k))) begin
          r_regs[k]    <= w_data;
          wr_strobe[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
  end

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(1 + ADDR_W);

  logic [DATA_W-1:0] r_tx, w_rd_sel;
  logic              r_rd, w_sck_fall;

  assign w_sck_fall = ~w_sck_s & r_sck_d;

  always_comb begin
    w_rd_sel = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      if (r_shift[ADDR_W-1:0] == ADDR_W'(k)) w_rd_sel = r_regs[k];
  end

  // Load one cycle after the header completes; shifting starts only after the first data bit is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx <= '0;
      r_rd <= 1'b0;
    end else if (w_clear) begin
      r_tx <= '0;
      r_rd <= 1'b0;
    end else if (r_state == SHIFT && r_cnt == CNT_HDR && !r_rd) begin
      r_rd <= r_shift[ADDR_W];
      r_tx <= r_shift[ADDR_W] ? w_rd_sel : '0;
    end else if (r_state == SHIFT && w_sck_fall && r_cnt > CNT_HDR) begin
      r_tx <= {r_tx[DATA_W-2:0], 1'b0};
    end
  end

  assign miso = r_rd & ~w_csb_s & r_tx[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Self-checking bench for spi_cfg_regbank: directed frames then random frames against an array model.
// Readback checks are compiled in when SPI_READBACK_EN is defined.
module tb_spi_cfg_regbank;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 4;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sck, mosi, csb;
  logic [127:0] regs_flat;
  logic [7:0]   wr_strobe;
  logic         frame_err;
`ifdef SPI_READBACK_EN
  logic         miso;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [15:0] m_regs [8];

  always #5 clk = ~clk;

  spi_cfg_regbank #(
    .ADDR_W(4), .DATA_W(16), .NUM_REGS(8), .SYNC_STAGES(SYNC), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .csb(csb),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .frame_err(frame_err)
`ifdef SPI_READBACK_EN
    , .miso(miso)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int unsigned k = 0; k < 8; k++) f[k*16 +: 16] = m_regs[k];
    return f;
  endfunction

  task automatic send_frame(input logic rw, input logic [3:0] addr, input logic [15:0] data,
                            input int unsigned nbits, input bit raise, output logic [15:0] rd);
    logic [20:0] w;
    w  = {rw, addr, data};
    rd = '0;
    @(negedge clk) csb = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = (i < 21) ? w[20-i] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
`ifdef SPI_READBACK_EN
      if (i >= 5 && i < 21) rd[20-i] = miso;
`endif
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    if (raise) begin
      repeat (HALF) @(negedge clk);
      csb = 1'b1;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic rw, input logic [3:0] addr,
                                 input logic [15:0] data, input int unsigned nbits);
    logic [7:0]   exp_strb;
    logic         exp_err;
    logic [127:0] old_flat, new_flat;
    logic [15:0]  rd, rd_exp;
    bit           in_rng;
    in_rng   = (addr < 4'd8);
    rd_exp   = in_rng ? m_regs[addr[2:0]] : 16'h0000;
    old_flat = model_flat();
    exp_strb = '0;
    exp_err  = 1'b0;
    if (nbits != 0) begin
      if (nbits == 21 && in_rng && !rw) begin
        m_regs[addr[2:0]] = data;
        exp_strb = 8'd1 << addr[2:0];
      end else if (!(nbits == 21 && in_rng && rw && RB)) begin
        exp_err = 1'b1;
      end
    end
    new_flat = model_flat();
    send_frame(rw, addr, data, nbits, 1'b1, rd);
    for (int unsigned c = 1; c <= SYNC + 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("%s c%0d strobe", tag, c), wr_strobe, (c == SYNC + 2) ? exp_strb : 8'h00);
      chk($sformatf("%s c%0d err", tag, c), frame_err, (c == SYNC + 2) ? exp_err : 1'b0);
      chk($sformatf("%s c%0d regs", tag, c), regs_flat, (c >= SYNC + 2) ? new_flat : old_flat);
    end
`ifdef SPI_READBACK_EN
    if (rw && nbits == 21) chk({tag, " miso"}, rd, rd_exp);
    chk({tag, " miso idle"}, miso, 1'b0);
`endif
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    logic [15:0] dummy;
    logic        rw;
    logic [3:0]  addr;
    int unsigned nb, sel;

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; csb = 1'b1;
    for (int unsigned k = 0; k < 8; k++) m_regs[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset regs", regs_flat, 128'h0);
    chk("reset strobe", wr_strobe, 8'h00);
    chk("reset err", frame_err, 1'b0);
`ifdef SPI_READBACK_EN
    chk("reset miso", miso, 1'b0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    frame_and_check("wr3", 1'b0, 4'd3, 16'hBEEF, 21);
    frame_and_check("short", 1'b0, 4'd2, 16'hA5A5, 20);
    frame_and_check("long", 1'b0, 4'd2, 16'hA5A5, 22);
    frame_and_check("addr9", 1'b0, 4'd9, 16'h1234, 21);
    frame_and_check("wr1", 1'b0, 4'd1, 16'h00FF, 21);

    // Asynchronous reset ten bits into a frame: everything returns to reset state.
    send_frame(1'b0, 4'd1, 16'h1111, 10, 1'b0, dummy);
    @(negedge clk);
    rst = 1'b1; csb = 1'b1; sck = 1'b0;
    #1;
    for (int unsigned k = 0; k < 8; k++) m_regs[k] = '0;
    chk("midrst regs", regs_flat, 128'h0);
    chk("midrst strobe", wr_strobe, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("postrst regs", regs_flat, 128'h0);
    chk("postrst err", frame_err, 1'b0);
    frame_and_check("wr1b", 1'b0, 4'd1, 16'h5A5A, 21);

    for (int unsigned t = 0; t < 3; t++) frame_and_check($sformatf("csbtog%0d", t), 1'b0, 4'd0, 16'h0, 0);

    frame_and_check("wr3b", 1'b0, 4'd3, 16'hBEEF, 21);
    frame_and_check("rd3", 1'b1, 4'd3, 16'h0000, 21);
    frame_and_check("rd12", 1'b1, 4'd12, 16'h0000, 21);

    for (int unsigned t = 0; t < 24; t++) begin
      rw   = ($urandom_range(0, 3) == 0);
      addr = 4'($urandom_range(0, 9));
      sel  = $urandom_range(0, 7);
      if (sel <= 4)      nb = 21;
      else if (sel == 5) nb = 20;
      else if (sel == 6) nb = 22 + $urandom_range(0, 3);
      else               nb = $urandom_range(1, 19);
      frame_and_check($sformatf("rnd%0d", t), rw, addr, 16'($urandom), nb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
- Parametrised SPI-slave configuration register bank for the 1-bit AM SDR core. It is the successor to the fixed SCK/MOSI/CSb configuration path.
- Generalised to NUM_REGS addressable registers of DATA_W bits each.
- Adds framed addressing, per-register write strobes, frame error reporting and optional readback.
- Sits between the chip pins (SCK, MOSI, CSb) and the NCO/gain/PWM configuration inputs of the SDR datapath, all in the clk domain.

Parameters:
ADDR_W, 4, address field width in bits
DATA_W, 16, register and data field width in bits
NUM_REGS, 8, number of implemented registers (must be <= 2**ADDR_W)
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (>= 2)
RESET_VAL, 0, reset value applied to every register (DATA_W bits)

Ports:
clk  in  1  system clock; must run at >= 4x the SCK frequency
rst  in  1  asynchronous active-high reset
sck  in  1  SPI clock, asynchronous to clk
mosi  in  1  SPI data in, asynchronous to clk
csb  in  1  SPI chip select, active low, asynchronous to clk
regs_flat  out  NUM_REGS*DATA_W  register contents; reg k occupies bits [k*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-cycle pulse on bit k when reg k is written
frame_err  out  1  one-cycle pulse on a rejected frame
miso  out  1  readback data; present only with SPI_READBACK_EN

Behaviour:
- Reset (async, rst=1):
  - all regs = RESET_VAL; wr_strobe = 0; frame_err = 0; miso = 0.
  - synchronisers cleared to idle (sck_s=0, mosi_s=0, csb_s=1); state = IDLE; bit counter and shift register = 0.
  - Reset mid-frame discards the partial frame. No strobe or error is issued for it.
- Synchronisation: sck, mosi and csb each pass through SYNC_STAGES flops. The edge detectors operate on the synchronised versions, one extra flop each.
- Frame format, MSB first, sampled on synchronised SCK rising edge while csb_s=0:
  - RW bit (1=read, 0=write)
  - ADDR_W address bits
  - DATA_W data bits
  - FRAME_LEN = 1+ADDR_W+DATA_W.
- Bit counter width is clog2(FRAME_LEN+2). It saturates at FRAME_LEN+1 ("overrun"). Extra bits beyond FRAME_LEN are ignored apart from forcing the overrun mark.
- State machine:
  - IDLE: stay while csb_s=1. On csb_s falling, clear counter and shift register, go to SHIFT.
  - SHIFT: on each sck_s rising edge, shift in mosi_s and increment the counter. On csb_s rising, go to COMMIT.
  - COMMIT (exactly one cycle): evaluate the frame, then go to IDLE, or straight to SHIFT (with a fresh clear) if csb_s is already low again.
- COMMIT evaluation:
  - count==0: ignored silently (CSb toggle without clocks).
  - count==FRAME_LEN, RW=0, addr<NUM_REGS: reg[addr] <= data and wr_strobe[addr]=1, both on the clk edge ending COMMIT.
  - count==FRAME_LEN, RW=1: no register change, no error (readback frame).
  - any other count, or addr>=NUM_REGS: frame_err=1 for one cycle, no register change.
- Latency: csb pin rising edge to regs_flat update and wr_strobe is SYNC_STAGES+2 clk cycles.
- Simultaneous events: an sck_s rising edge in the same cycle as a csb_s rising edge is not counted.
- At most one bit of wr_strobe is ever set in a cycle. wr_strobe and frame_err are mutually exclusive.

Optional Feature:
SPI_READBACK_EN
- Defined:
  - miso port exists.
  - When the counter reaches 1+ADDR_W with RW=1, reg[addr] (or 0 if addr>=NUM_REGS) is loaded into a DATA_W transmit shifter.
  - miso presents the MSB immediately and shifts on each following sck_s falling edge.
  - miso = 0 whenever csb_s=1 or the frame is a write.
  - An out-of-range read also pulses frame_err at COMMIT.
- Undefined:
  - No miso port, no transmit shifter.
  - RW=1 frames of FRAME_LEN bits are rejected with a frame_err pulse.

Test Plan:
- Write frame RW=0, addr=3, data=0xBEEF (21 bits) -> SYNC_STAGES+2 cycles after CSb rises:
  - reg3=0xBEEF
  - wr_strobe=8'b0000_1000 for exactly one cycle
  - other regs unchanged at 0, frame_err=0.
- 20-bit write to addr 2, then 22-bit write to addr 2 -> each frame gives one frame_err pulse; reg2 stays 0x0000; wr_strobe stays 0.
- Write to addr 9 with data 0x1234 (NUM_REGS=8) -> frame_err pulses once; all regs unchanged.
- Write addr 1 = 0x00FF, then assert rst after 10 bits of a second write to addr 1 -> all regs return to 0x0000. A fresh write addr 1 = 0x5A5A then lands correctly with a single strobe.
- CSb low/high with no SCK edges, repeated 3 times -> no strobe, no frame_err, regs unchanged.
- With SPI_READBACK_EN: write addr 3 = 0xBEEF, then read frame addr 3 -> the 16 miso bits after the address field equal 0xBEEF MSB first. With the feature off, the same read frame produces a frame_err pulse.
